instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage directly upstream of the control path: holds the program counter, issues single-outstanding reads to instruction memory, and buffers returned words in a 2-entry queue whose head drives the instruction word decoded downstream. It takes the branch/jump redirect (`PCSrc` plus target) back from the execute side and discards wrong-path fetches.

## Interface
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset.
- `iClk`  in  1  clock, all state updates on rising edge.
- `iRstN`  in  1  asynchronous active-low reset.
- `iStall`  in  1  downstream not accepting; head is held while high.
- `iPCSrc`  in  1  redirect request for the instruction currently at the queue head.
- `iBranchTarget`  in  [32:1]  redirect address; bits [2:1] ignored, treated as 0.
- `oImemReq`  out  1  instruction memory read request.
- `oImemAddr`  out  [32:1]  read address, word aligned.
- `iImemReady`  in  1  memory response; `iImemData` is valid in the same cycle.
- `iImemData`  in  [32:1]  returned instruction word.
- `oInstruction`  out  [32:1]  queue head instruction, 0 when empty.
- `oPC`  out  [32:1]  address of the head instruction, 0 when empty.
- `oPCPlus4`  out  [32:1]  `oPC + 4`, combinational, modulo 2^32.
- `oValid`  out  1  queue non-empty; head is presented.

## Operation
- Pop: the head is consumed in any cycle with `oValid && !iStall`.
- Redirect: taken only when `iPCSrc && oValid && !iStall`; otherwise `iPCSrc` is ignored. The head, which is the branch itself, is consumed; the second queue entry is flushed; `pc <= {iBranchTarget[32:3], 2'b00}`.
- Memory protocol: once `oImemReq` rises, it and `oImemAddr` stay stable until a cycle with `iImemReady=1`. That cycle completes the transfer. `iImemReady` is ignored while `oImemReq=0`. Zero-wait responses are legal, with ready high in the first request cycle.
- A request is started only when the queue has a free entry after this cycle's pop, so returned data is always written.
- FSM states:
  - IDLE: `oImemReq=0`. Next state is REQ if occupancy after pop is < 2; else stays IDLE. A redirect in IDLE loads pc and then applies the same rule, which always gives REQ because the queue is empty.
  - REQ: `oImemReq=1`, `oImemAddr=pc`.
    - Ready with no redirect: push `{iImemData, pc}` and set `pc <= pc+4`. Stay in REQ if occupancy after push and pop is < 2, else go to IDLE.
    - Ready coinciding with a redirect: discard the data, load the target, go to REQ. The queue is empty.
    - Redirect without ready: latch the target into the redirect register and go to DRAIN.
  - DRAIN: `oImemReq=1` and the old address is held. On ready, discard the data, set `pc <=` redirect register, go to REQ. `oValid=0` throughout, so no further redirect can occur.
- Queue: 2 entries with read pointer, write pointer and 2-bit count. Push and pop in the same cycle are legal at any occupancy. Push at count 2 cannot occur by construction; the bench checks this with an assertion.
- PC arithmetic is 32-bit unsigned, and increments wrap `32'hFFFF_FFFC -> 0`.

## Timing
- Reset (async assert, sync release) values:
  - state IDLE, `pc = RESET_PC`, count 0, redirect register 0.
  - `oImemReq=0`, `oImemAddr=RESET_PC`, `oValid=0`, `oInstruction=0`, `oPC=0`, `oPCPlus4=4`.
- First request in the first cycle after reset release (REQ entered at that edge).
- Fetch latency: a word accepted at edge N is visible on `oInstruction`/`oValid` from cycle N+1.
- Sustained throughput is 1 instruction/cycle with zero-wait memory and no stall.
- Redirect penalty with a zero-wait memory:
  - Redirect at edge N.
  - Target requested in cycle N+1.
  - Target valid at head in cycle N+2.
- Reset asserted mid-transaction abandons the outstanding request immediately; the memory must tolerate `oImemReq` dropping.
- `oInstruction`, `oPC` and `oValid` are registered queue outputs, with no combinational path from `iImemData`. `oImemReq` is a pure function of state.

## Test plan
- Reset release with `RESET_PC=32'h100`, zero-wait memory returning `addr ^ 32'hA5A5_0000`, no stall: `oPC` = 0x100, 0x104, 0x108 on consecutive cycles starting 2 cycles after release, with `oValid` continuous.
- Stall held 5 cycles after the first valid: queue fills to 2, then `oImemReq=0`, head 0x100 stays stable. On release, 0x100, 0x104, 0x108 appear in order with no loss or duplicate.
- Memory with 3-cycle wait and a redirect to `32'h200` issued mid-wait: `oImemAddr` holds its old value until ready. That data is dropped, the next request is to 0x200, and the next `oPC` after the branch is 0x200.
- Redirect to `32'h303` in the same cycle as a zero-wait response: the response is discarded and the next request goes to 0x300.
- `iPCSrc=1` while `oValid=0` or `iStall=1`: pc unchanged and sequential fetch continues.
- `RESET_PC=32'hFFFF_FFF8`, no stall: `oPC` sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; `oPCPlus4` wraps to 0 on the second.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Instruction memory read channel between the fetch stage (master) and memory (slave).
// A request holds req/addr stable until a cycle with ready high; data is valid in that cycle.
interface instruction_fetch_if;
    logic        imem_req;
    logic [32:1] imem_addr;
    logic        imem_ready;
    logic [32:1] imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_data
    );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: program counter, single-outstanding imem reads, 2-entry instruction queue
// and branch/jump redirect with wrong-path discard.
module instruction_fetch #(
    parameter logic [32:1] RESET_PC = 32'h0000_0000
) (
    input  logic                 iClk,
    input  logic                 iRstN,
    input  logic                 iStall,
    input  logic                 iPCSrc,
    input  logic [32:1]          iBranchTarget,
    instruction_fetch_if.master  imem,
    output logic [32:1]          oInstruction,
    output logic [32:1]          oPC,
    output logic [32:1]          oPCPlus4,
    output logic                 oValid
);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t      state;
    logic [32:1] pc;
    logic [32:1] redir_pc;
    logic [32:1] q_instr [0:1];
    logic [32:1] q_pc    [0:1];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;

    logic        pop;
    logic        redirect;
    logic        ready;
    logic        push;
    logic [1:0]  count_pop;
    logic [32:1] target;

    assign pop       = oValid && !iStall;
    assign redirect  = pop && iPCSrc;
    assign ready     = (state != IDLE) && imem.imem_ready;
    assign push      = (state == REQ) && imem.imem_ready && !redirect;
    assign count_pop = count - {1'b0, pop};
    assign target    = iBranchTarget & 32'hFFFF_FFFC;

    assign imem.imem_req  = (state != IDLE);
    assign imem.imem_addr = pc;

    assign oValid       = (count != 2'd0);
    assign oInstruction = oValid ? q_instr[rd_ptr] : '0;
    assign oPC          = oValid ? q_pc[rd_ptr]    : '0;
    assign oPCPlus4     = oPC + 32'd4;

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            redir_pc <= '0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= 2'd0;
        end else begin
            // A taken redirect consumes the branch and flushes anything fetched behind it.
            if (redirect) begin
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
                count  <= 2'd0;
            end else begin
                if (pop)  rd_ptr <= ~rd_ptr;
                if (push) wr_ptr <= ~wr_ptr;
                count <= count_pop + {1'b0, push};
            end

            case (state)
                IDLE: begin
                    if (redirect) begin
                        pc    <= target;
                        state <= REQ;
                    end else if (count_pop != 2'd2) begin
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (redirect) begin
                        if (ready) begin
                            pc    <= target;
                            state <= REQ;
                        end else begin
                            redir_pc <= target;
                            state    <= DRAIN;
                        end
                    end else if (ready) begin
                        pc    <= pc + 32'd4;
                        // Only keep requesting if the pushed word still leaves a free slot.
                        state <= (count_pop == 2'd0) ? REQ : IDLE;
                    end
                end
                DRAIN: begin
                    if (ready) begin
                        pc    <= redir_pc;
                        state <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge iClk) begin
        if (push) begin
            q_instr[wr_ptr] <= imem.imem_data;
            q_pc[wr_ptr]    <= pc;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: two instances (RESET_PC 0x100 and 0xFFFF_FFF8)
// each fed by a small instruction memory model returning addr ^ 0xA5A5_0000.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        pcsrc;
    logic [32:1] target;

    logic [32:1] instr_a, pc_a, pc4_a;
    logic        valid_a;
    logic [32:1] instr_b, pc_b, pc4_b;
    logic        valid_b;

    int errors = 0;
    int checks = 0;
    int overflow_errs = 0;
    int wait_a = 0;
    int wcnt_a;

    instruction_fetch_if if_a ();
    instruction_fetch_if if_b ();

    instruction_fetch #(.RESET_PC(32'h0000_0100)) dut_a (
        .iClk          (clk),
        .iRstN         (rst_n),
        .iStall        (stall),
        .iPCSrc        (pcsrc),
        .iBranchTarget (target),
        .imem          (if_a.master),
        .oInstruction  (instr_a),
        .oPC           (pc_a),
        .oPCPlus4      (pc4_a),
        .oValid        (valid_a)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_b (
        .iClk          (clk),
        .iRstN         (rst_n),
        .iStall        (1'b0),
        .iPCSrc        (1'b0),
        .iBranchTarget (32'h0),
        .imem          (if_b.master),
        .oInstruction  (instr_b),
        .oPC           (pc_b),
        .oPCPlus4      (pc4_b),
        .oValid        (valid_b)
    );

    always #5 clk = ~clk;

    // Memory A: ready after wait_a cycles of an outstanding request
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) wcnt_a <= 0;
        else if (if_a.imem_req && if_a.imem_ready) wcnt_a <= 0;
        else if (if_a.imem_req) wcnt_a <= wcnt_a + 1;
        else wcnt_a <= 0;
    end
    assign if_a.imem_ready = if_a.imem_req && (wcnt_a == wait_a);
    assign if_a.imem_data  = if_a.imem_addr ^ 32'hA5A5_0000;

    assign if_b.imem_ready = if_b.imem_req;
    assign if_b.imem_data  = if_b.imem_addr ^ 32'hA5A5_0000;

    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(dut_a.push && dut_a.count == 2'd2)) else begin
                overflow_errs++;
                $display("FAIL queue_overflow: push seen at count %0d, required below 2", dut_a.count);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        stall  = 1'b0;
        pcsrc  = 1'b0;
        target = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        wait_a = 0;
        rst_n  = 1'b0;
        stall  = 1'b0;
        pcsrc  = 1'b0;
        target = '0;
        step();
        checks++; if (if_a.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b required 0", if_a.imem_req); end
        checks++; if (if_a.imem_addr !== 32'h100) begin errors++; $display("FAIL reset_addr: got %h required 00000100", if_a.imem_addr); end
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", valid_a); end
        checks++; if (instr_a !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h required 0", instr_a); end
        checks++; if (pc_a !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h required 0", pc_a); end
        checks++; if (pc4_a !== 32'h4) begin errors++; $display("FAIL reset_pcplus4: got %h required 4", pc4_a); end
        checks++; if (if_b.imem_addr !== 32'hFFFF_FFF8) begin errors++; $display("FAIL reset_addr_b: got %h required fffffff8", if_b.imem_addr); end
    endtask

    task automatic test_sequential();
        logic [32:1] exp_pc;
        wait_a = 0;
        do_reset();
        step();
        checks++; if (if_a.imem_req !== 1'b1 || if_a.imem_addr !== 32'h100) begin errors++; $display("FAIL seq_first_req: got req=%b addr=%h required req=1 addr=00000100", if_a.imem_req, if_a.imem_addr); end
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL seq_latency: valid got %b required 0", valid_a); end
        exp_pc = 32'h100;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (valid_a !== 1'b1 || pc_a !== exp_pc) begin errors++; $display("FAIL seq_pc[%0d]: got valid=%b pc=%h required valid=1 pc=%h", i, valid_a, pc_a, exp_pc); end
            checks++; if (instr_a !== (exp_pc ^ 32'hA5A5_0000) || pc4_a !== exp_pc + 32'd4) begin errors++; $display("FAIL seq_instr[%0d]: got instr=%h pc4=%h required instr=%h pc4=%h", i, instr_a, pc4_a, exp_pc ^ 32'hA5A5_0000, exp_pc + 32'd4); end
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic test_stall();
        wait_a = 0;
        do_reset();
        step();
        step();
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (pc_a !== 32'h100 || valid_a !== 1'b1) begin errors++; $display("FAIL stall_hold[%0d]: got pc=%h valid=%b required pc=00000100 valid=1", i, pc_a, valid_a); end
            checks++; if (if_a.imem_req !== 1'b0) begin errors++; $display("FAIL stall_req_off[%0d]: got req=%b required 0", i, if_a.imem_req); end
        end
        stall = 1'b0;
        step();
        checks++; if (pc_a !== 32'h104 || valid_a !== 1'b1) begin errors++; $display("FAIL stall_release_1: got pc=%h valid=%b required pc=00000104 valid=1", pc_a, valid_a); end
        checks++; if (if_a.imem_req !== 1'b1 || if_a.imem_addr !== 32'h108) begin errors++; $display("FAIL stall_refetch: got req=%b addr=%h required req=1 addr=00000108", if_a.imem_req, if_a.imem_addr); end
        step();
        checks++; if (pc_a !== 32'h108 || valid_a !== 1'b1) begin errors++; $display("FAIL stall_release_2: got pc=%h valid=%b required pc=00000108 valid=1", pc_a, valid_a); end
    endtask

    task automatic test_redirect_wait();
        bit seen;
        wait_a = 3;
        do_reset();
        step();
        checks++; if (if_a.imem_req !== 1'b1 || if_a.imem_addr !== 32'h100) begin errors++; $display("FAIL wait_first_req: got req=%b addr=%h required req=1 addr=00000100", if_a.imem_req, if_a.imem_addr); end
        for (int i = 0; i < 3; i++) step();
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL wait_not_early: valid got %b required 0", valid_a); end
        step();
        checks++; if (valid_a !== 1'b1 || pc_a !== 32'h100) begin errors++; $display("FAIL wait_head: got valid=%b pc=%h required valid=1 pc=00000100", valid_a, pc_a); end
        pcsrc  = 1'b1;
        target = 32'h200;
        step();
        pcsrc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (if_a.imem_req !== 1'b1 || if_a.imem_addr !== 32'h104 || valid_a !== 1'b0) begin errors++; $display("FAIL drain_hold[%0d]: got req=%b addr=%h valid=%b required req=1 addr=00000104 valid=0", i, if_a.imem_req, if_a.imem_addr, valid_a); end
            step();
        end
        checks++; if (if_a.imem_req !== 1'b1 || if_a.imem_addr !== 32'h200) begin errors++; $display("FAIL drain_target_req: got req=%b addr=%h required req=1 addr=00000200", if_a.imem_req, if_a.imem_addr); end
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            seen = valid_a;
        end
        checks++; if (!seen || pc_a !== 32'h200) begin errors++; $display("FAIL drain_branch_pc: got valid=%b pc=%h required valid=1 pc=00000200", valid_a, pc_a); end
    endtask

    task automatic test_redirect_zero_wait();
        wait_a = 0;
        do_reset();
        step();
        step();
        pcsrc  = 1'b1;
        target = 32'h303;
        step();
        pcsrc = 1'b0;
        checks++; if (if_a.imem_req !== 1'b1 || if_a.imem_addr !== 32'h300 || valid_a !== 1'b0) begin errors++; $display("FAIL zw_redirect_req: got req=%b addr=%h valid=%b required req=1 addr=00000300 valid=0", if_a.imem_req, if_a.imem_addr, valid_a); end
        step();
        checks++; if (valid_a !== 1'b1 || pc_a !== 32'h300 || instr_a !== 32'hA5A5_0300) begin errors++; $display("FAIL zw_redirect_head: got valid=%b pc=%h instr=%h required valid=1 pc=00000300 instr=a5a50300", valid_a, pc_a, instr_a); end
        step();
        checks++; if (pc_a !== 32'h304) begin errors++; $display("FAIL zw_after_target: got pc=%h required 00000304", pc_a); end
    endtask

    task automatic test_pcsrc_ignored();
        wait_a = 0;
        do_reset();
        step();
        pcsrc  = 1'b1;
        target = 32'h500;
        step();
        pcsrc = 1'b0;
        checks++; if (pc_a !== 32'h100 || if_a.imem_addr !== 32'h104) begin errors++; $display("FAIL ignore_invalid: got pc=%h addr=%h required pc=00000100 addr=00000104", pc_a, if_a.imem_addr); end
        step();
        stall  = 1'b1;
        pcsrc  = 1'b1;
        target = 32'h500;
        step();
        stall = 1'b0;
        pcsrc = 1'b0;
        checks++; if (pc_a !== 32'h104 || if_a.imem_req !== 1'b0) begin errors++; $display("FAIL ignore_stalled: got pc=%h req=%b required pc=00000104 req=0", pc_a, if_a.imem_req); end
        step();
        checks++; if (pc_a !== 32'h108 || if_a.imem_addr !== 32'h10C) begin errors++; $display("FAIL ignore_continue: got pc=%h addr=%h required pc=00000108 addr=0000010c", pc_a, if_a.imem_addr); end
    endtask

    task automatic test_wrap();
        wait_a = 0;
        do_reset();
        step();
        step();
        checks++; if (valid_b !== 1'b1 || pc_b !== 32'hFFFF_FFF8 || pc4_b !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_0: got valid=%b pc=%h pc4=%h required valid=1 pc=fffffff8 pc4=fffffffc", valid_b, pc_b, pc4_b); end
        step();
        checks++; if (valid_b !== 1'b1 || pc_b !== 32'hFFFF_FFFC || pc4_b !== 32'h0) begin errors++; $display("FAIL wrap_1: got valid=%b pc=%h pc4=%h required valid=1 pc=fffffffc pc4=00000000", valid_b, pc_b, pc4_b); end
        step();
        checks++; if (valid_b !== 1'b1 || pc_b !== 32'h0 || pc4_b !== 32'h4 || instr_b !== 32'hA5A5_0000) begin errors++; $display("FAIL wrap_2: got valid=%b pc=%h pc4=%h instr=%h required valid=1 pc=0 pc4=4 instr=a5a50000", valid_b, pc_b, pc4_b, instr_b); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_zero_wait();
        test_pcsrc_ignored();
        test_wrap();
        errors = errors + overflow_errs;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
